// File: rtl/dbus_pkg.sv
// Shared data-bus encodings: access widths, register offsets, STATUS bit positions, UART FSM states.
package dbus_pkg;

  localparam logic [1:0] W_WORD = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_BYTE = 2'b10;
  localparam logic [1:0] W_RSVD = 2'b11;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DIV    = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 8;

  localparam logic [15:0] DIV_MIN = 16'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head; a push while full is accepted only if a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers are AW bits wide, so power-of-two depth wraps for free.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dbus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU data bus: TXDATA/STATUS/DIV window, queued bytes, tx-done irq.
module dbus_uart_tx
  import dbus_pkg::*;
#(
  parameter logic [31:0] BASE    = 32'h1000_0000,
  parameter logic [15:0] DIV_RST = 16'd868,
  parameter int          DEPTH   = 8,
  localparam int         AW      = $clog2(DEPTH)
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic [1:0]  w_cs,
  input  logic [1:0]  r_cs,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        irq
);

  tx_state_t   state;
  logic [7:0]  shift;
  logic [15:0] div;
  logic [15:0] bit_per;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic        ovf;

  logic        sel;
  logic [1:0]  off;
  logic        wr;
  logic        push;
  logic        pop;
  logic [7:0]  head;
  logic        full;
  logic        empty;
  logic [AW:0] count;
  logic [6:0]  count7;
  logic        busy;
  logic        bit_end;
  logic        unused;

  // Every write is handled as a full word, so width codes and the low/high address/data bits carry no meaning here.
  assign unused = ^{w_cs, r_cs, addr[1:0], wdata[31:16]};

  assign sel    = cs && (addr[31:4] == BASE[31:4]);
  assign off    = addr[3:2];
  assign wr     = sel && we;
  assign push   = wr && (off == OFF_TXDATA);
  assign pop    = (state == S_IDLE) && !empty;
  assign busy   = (state != S_IDLE);
  assign irq    = empty && !busy;
  assign count7 = 7'(count);

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk_in    (clk_in),
    .reset     (reset),
    .push      (push),
    .push_data (wdata[7:0]),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (off)
        OFF_STATUS: begin
          rdata[ST_FULL]                  = full;
          rdata[ST_EMPTY]                 = empty;
          rdata[ST_BUSY]                  = busy;
          rdata[ST_OVF]                   = ovf;
          rdata[ST_CNT_LSB+6:ST_CNT_LSB]  = count7;
        end
        OFF_DIV: rdata[15:0] = div;
        default: rdata = '0;
      endcase
    end
  end

  // A dropped push outranks a clear landing on the same edge.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
      div <= DIV_RST;
    end else begin
      if (push && full && !pop)
        ovf <= 1'b1;
      else if (wr && (off == OFF_STATUS) && wdata[ST_OVF])
        ovf <= 1'b0;
      if (wr && (off == OFF_DIV))
        div <= (wdata[15:0] < DIV_MIN) ? DIV_MIN : wdata[15:0];
    end
  end

  assign bit_end = (baud_cnt == bit_per - 16'd1);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      txd      <= 1'b1;
      shift    <= '0;
      bit_per  <= DIV_RST;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          txd      <= 1'b1;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (!empty) begin
            shift   <= head;
            bit_per <= div;
            txd     <= 1'b0;
            state   <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            txd      <= shift[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              txd   <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              txd     <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_uart_tx.sv
// Directed bench for dbus_uart_tx: register window, framing/timing, overflow, divisor handling and reset abort.
module tb_dbus_uart_tx;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b1;
  logic        cs     = 1'b0;
  logic        we     = 1'b0;
  logic [1:0]  w_cs   = 2'b00;
  logic [1:0]  r_cs   = 2'b00;
  logic [31:0] addr   = '0;
  logic [31:0] wdata  = '0;
  logic [31:0] rdata;
  logic        txd;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  dbus_uart_tx #(.BASE(BASE), .DIV_RST(16'd868), .DEPTH(8)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .cs     (cs),
    .we     (we),
    .w_cs   (w_cs),
    .r_cs   (r_cs),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .txd    (txd),
    .irq    (irq)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Drives one write across exactly one posedge; returns on the following negedge.
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic c = 1'b1);
    cs = c; we = 1'b1; addr = a; wdata = d; w_cs = 2'b10;
    @(negedge clk_in);
    cs = 1'b0; we = 1'b0; addr = '0; wdata = '0; w_cs = 2'b00;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, input logic c = 1'b1);
    cs = c; we = 1'b0; addr = a; r_cs = 2'b01;
    #1 d = rdata;
    cs = 1'b0; addr = '0; r_cs = 2'b00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
  endtask

  // Waits for the start bit, then checks every cycle of the 10-bit frame against the expected waveform.
  // Optionally issues a DIV write after sample mid_k to exercise mid-frame divisor changes.
  task automatic capture(input string tag, input logic [7:0] data, input int div,
                         input int mid_k, input logic [15:0] mid_div, output int lat);
    int bad;
    logic [9:0] frame;
    bad   = 0;
    lat   = 0;
    frame = {1'b1, data, 1'b0};
    while (txd !== 1'b0 && lat < 3000) begin
      @(negedge clk_in);
      lat++;
    end
    check_eq({tag, "_start"}, {31'd0, txd}, 32'd0);
    if (txd === 1'b0) begin
      for (int k = 0; k < 10 * div; k++) begin
        if (k > 0) @(negedge clk_in);
        if (txd !== frame[k / div]) bad++;
        if (k == mid_k) begin
          cs = 1'b1; we = 1'b1; addr = BASE + 32'h8; wdata = {16'd0, mid_div};
        end
        if (k == mid_k + 1) begin
          cs = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        end
      end
    end
    check_eq({tag, "_bits"}, bad, 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    int lat;
    int bad;

    // Reset state
    do_reset();
    check_eq("rst_txd", {31'd0, txd}, 32'd1);
    check_eq("rst_irq", {31'd0, irq}, 32'd1);
    bus_rd(BASE + 32'h4, d); check_eq("rst_status", d, 32'h0000_0002);
    bus_rd(BASE + 32'h8, d); check_eq("rst_div", d, 32'd868);

    // Single frame, DIV=4, 0x55: fall one edge after the write, irq back 41 cycles after the write
    @(negedge clk_in);
    bus_wr(BASE + 32'h8, 32'd4);
    bus_wr(BASE, 32'h0000_0055);
    check_eq("f1_txd_before", {31'd0, txd}, 32'd1);
    capture("f1", 8'h55, 4, -1, 16'd0, lat);
    check_eq("f1_latency", lat, 32'd1);
    check_eq("f1_irq_stop", {31'd0, irq}, 32'd0);
    @(negedge clk_in);
    check_eq("f1_irq_done", {31'd0, irq}, 32'd1);
    bus_rd(BASE + 32'h4, d); check_eq("f1_status_idle", d, 32'h0000_0002);

    // Divisor clamp and read-back
    @(negedge clk_in);
    bus_wr(BASE + 32'h8, 32'd1);
    bus_rd(BASE + 32'h8, d); check_eq("div_clamp1", d, 32'd2);
    @(negedge clk_in);
    bus_wr(BASE + 32'h8, 32'h0001_0000);
    bus_rd(BASE + 32'h8, d); check_eq("div_clamp0", d, 32'd2);

    // Mid-frame DIV change: frame 1 stays at 4, frame 2 runs at 8 after one idle cycle
    @(negedge clk_in);
    bus_wr(BASE + 32'h8, 32'd4);
    bus_wr(BASE, 32'h0000_0055);
    bus_wr(BASE, 32'h0000_00C3);
    capture("m1", 8'h55, 4, 5, 16'd8, lat);
    check_eq("m1_latency", lat, 32'd0);
    capture("m2", 8'hC3, 8, -1, 16'd0, lat);
    check_eq("m2_gap", lat, 32'd2);
    bus_rd(BASE + 32'h8, d); check_eq("m_div", d, 32'd8);

    // Overflow: DEPTH=8, DIV=100, ten back-to-back bytes
    do_reset();
    bus_wr(BASE + 32'h8, 32'd100);
    for (int i = 0; i < 10; i++) bus_wr(BASE, 32'h30 + i);
    bus_rd(BASE + 32'h4, d); check_eq("ovf_status", d, 32'h0000_080D);
    @(negedge clk_in);
    bus_wr(BASE + 32'h4, 32'h0000_0007);
    bus_rd(BASE + 32'h4, d); check_eq("ovf_keep", d, 32'h0000_080D);
    @(negedge clk_in);
    bus_wr(BASE + 32'h4, 32'h0000_0008);
    bus_rd(BASE + 32'h4, d); check_eq("ovf_clear", d, 32'h0000_0805);
    @(negedge clk_in);
    bus_wr(BASE, 32'h0000_00EE);
    bus_rd(BASE + 32'h4, d); check_eq("ovf_reset", d, 32'h0000_080D);

    // Reset during DATA bit 3 with a byte still queued
    do_reset();
    bus_wr(BASE + 32'h8, 32'd4);
    bus_wr(BASE, 32'h0000_00A5);
    bus_wr(BASE, 32'h0000_003C);
    check_eq("ra_in_start", {31'd0, txd}, 32'd0);
    repeat (17) @(negedge clk_in);
    #1 reset = 1'b1;
    #1 check_eq("ra_txd_now", {31'd0, txd}, 32'd1);
    bus_rd(BASE + 32'h4, d); check_eq("ra_status_in_rst", d, 32'h0000_0002);
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    bus_rd(BASE + 32'h4, d); check_eq("ra_status", d, 32'h0000_0002);
    bus_rd(BASE + 32'h8, d); check_eq("ra_div", d, 32'd868);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_in);
      if (txd !== 1'b1 || irq !== 1'b1) bad++;
    end
    check_eq("ra_quiet", bad, 32'd0);

    // Unselected / out-of-window accesses leave everything alone
    bus_rd(BASE + 32'h20, d); check_eq("ns_rd_window", d, 32'd0);
    bus_rd(BASE + 32'h4, d, 1'b0); check_eq("ns_rd_cs0", d, 32'd0);
    bus_rd(BASE + 32'h0, d); check_eq("rd_txdata", d, 32'd0);
    bus_rd(BASE + 32'hC, d); check_eq("rd_off3", d, 32'd0);
    @(negedge clk_in);
    bus_wr(BASE, 32'h0000_0011, 1'b0);
    bus_wr(BASE + 32'h20, 32'h0000_0011);
    bus_wr(BASE + 32'h28, 32'd5);
    bus_wr(BASE + 32'h8, 32'd6, 1'b0);
    bus_wr(BASE + 32'hC, 32'hFFFF_FFFF);
    bus_rd(BASE + 32'h4, d); check_eq("ns_status", d, 32'h0000_0002);
    bus_rd(BASE + 32'h8, d); check_eq("ns_div", d, 32'd868);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (txd !== 1'b1) bad++;
    end
    check_eq("ns_txd_idle", bad, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
